// File: rtl/voice_pkg.sv
// Shared types and field widths for the voice scheduler slice.
package voice_pkg;

  localparam int unsigned NOTE_W   = 6;
  localparam int unsigned DUR_W    = 6;
  localparam int unsigned STEREO_W = 2;

  localparam logic [NOTE_W-1:0] REST_NOTE = 6'd0;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/voice_picker.sv
// Combinational voice selection: lowest-index free voice, otherwise (when
// stealing is enabled) the oldest busy voice with ties to the lowest index.
module voice_picker #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned AGE_W      = 8,
  parameter bit          STEAL_EN   = 1'b1,
  parameter int unsigned SEL_W      = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]            busy,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] age,
  output logic [SEL_W-1:0]                 sel,
  output logic                             sel_valid,
  output logic                             sel_is_steal
);

  logic             found;
  logic [SEL_W-1:0] free_sel;
  logic [SEL_W-1:0] old_sel;
  logic [AGE_W-1:0] old_age;

  always_comb begin
    found    = 1'b0;
    free_sel = '0;
    old_sel  = '0;
    old_age  = age[0];
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!found && !busy[i]) begin
        found    = 1'b1;
        free_sel = SEL_W'(i);
      end
    end
    // strict greater-than keeps the lowest index on equal ages
    for (int unsigned i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > old_age) begin
        old_age = age[i];
        old_sel = SEL_W'(i);
      end
    end
    sel          = found ? free_sel : old_sel;
    sel_valid    = found || STEAL_EN;
    sel_is_steal = !found && STEAL_EN;
  end

endmodule

// File: rtl/voice_scheduler.sv
// Allocates song-reader note requests onto a pool of note_players, tracking
// busy/age per voice and issuing one-cycle load pulses with the note fields.
module voice_scheduler
  import voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned AGE_W      = 8,
  parameter bit          STEAL_EN   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           beat,
  input  logic                           play_enable,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [NOTE_W-1:0]              req_note,
  input  logic [DUR_W-1:0]               req_duration,
  input  logic [STEREO_W-1:0]            req_stereo,
  input  logic [NUM_VOICES-1:0]          voice_done,
  output logic [NUM_VOICES-1:0]          voice_load,
  output logic [NOTE_W*NUM_VOICES-1:0]   voice_note,
  output logic [DUR_W*NUM_VOICES-1:0]    voice_duration,
  output logic [STEREO_W*NUM_VOICES-1:0] voice_stereo,
  output logic [NUM_VOICES-1:0]          voices_busy,
  output logic                           req_done,
  output logic                           steal_pulse
);

  localparam int unsigned SEL_W = $clog2(NUM_VOICES);

  state_e                                  state_q, state_d;
  logic [NOTE_W-1:0]                       rnote_q, rnote_d;
  logic [DUR_W-1:0]                        rdur_q, rdur_d;
  logic [STEREO_W-1:0]                     rstereo_q, rstereo_d;
  logic [SEL_W-1:0]                        sel_q, sel_d;
  logic [NUM_VOICES-1:0]                   busy_q, busy_d;
  logic [NUM_VOICES-1:0]                   load_q, load_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]        age_q, age_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]       vnote_q, vnote_d;
  logic [NUM_VOICES-1:0][DUR_W-1:0]        vdur_q, vdur_d;
  logic [NUM_VOICES-1:0][STEREO_W-1:0]     vstereo_q, vstereo_d;
  logic                                    req_done_q, req_done_d;
  logic                                    steal_q, steal_d;

  logic [SEL_W-1:0] pick_sel;
  logic             pick_valid;
  logic             pick_steal;
  logic             hs;
  logic             tick;
  logic             load_hit;

  voice_picker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .STEAL_EN   (STEAL_EN),
    .SEL_W      (SEL_W)
  ) u_picker (
    .busy         (busy_q),
    .age          (age_q),
    .sel          (pick_sel),
    .sel_valid    (pick_valid),
    .sel_is_steal (pick_steal)
  );

  assign req_ready = reset & play_enable & (state_q == IDLE);
  assign hs        = req_valid & req_ready;
  assign tick      = beat & play_enable;

  // Pulses and voice fields are registered on leaving ALLOC/DONE so they all
  // appear together two cycles after the handshake; busy/age follow in LOAD.
  always_comb begin
    state_d    = state_q;
    rnote_d    = rnote_q;
    rdur_d     = rdur_q;
    rstereo_d  = rstereo_q;
    sel_d      = sel_q;
    vnote_d    = vnote_q;
    vdur_d     = vdur_q;
    vstereo_d  = vstereo_q;
    load_d     = '0;
    req_done_d = 1'b0;
    steal_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          rnote_d   = req_note;
          rdur_d    = req_duration;
          rstereo_d = req_stereo;
          state_d   = (req_note == REST_NOTE) ? DONE : ALLOC;
        end
      end
      ALLOC: begin
        if (pick_valid) begin
          sel_d              = pick_sel;
          vnote_d[pick_sel]  = rnote_q;
          vdur_d[pick_sel]   = rdur_q;
          vstereo_d[pick_sel] = rstereo_q;
          load_d[pick_sel]   = 1'b1;
          req_done_d         = 1'b1;
          steal_d            = pick_steal;
          state_d            = LOAD;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      DONE: begin
        req_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d   = busy_q;
    age_d    = age_q;
    load_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      load_hit  = (state_q == LOAD) && (sel_q == SEL_W'(i));
      busy_d[i] = (busy_q[i] & ~voice_done[i]) | load_hit;
      if (load_hit || !busy_d[i]) begin
        age_d[i] = '0;
      end else if (busy_q[i] && tick && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rnote_q    <= '0;
      rdur_q     <= '0;
      rstereo_q  <= '0;
      sel_q      <= '0;
      busy_q     <= '0;
      load_q     <= '0;
      age_q      <= '0;
      vnote_q    <= '0;
      vdur_q     <= '0;
      vstereo_q  <= '0;
      req_done_q <= 1'b0;
      steal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnote_q    <= rnote_d;
      rdur_q     <= rdur_d;
      rstereo_q  <= rstereo_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      age_q      <= age_d;
      vnote_q    <= vnote_d;
      vdur_q     <= vdur_d;
      vstereo_q  <= vstereo_d;
      req_done_q <= req_done_d;
      steal_q    <= steal_d;
    end
  end

  assign voice_load     = load_q;
  assign voice_note     = vnote_q;
  assign voice_duration = vdur_q;
  assign voice_stereo   = vstereo_q;
  assign voices_busy    = busy_q;
  assign req_done       = req_done_q;
  assign steal_pulse    = steal_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: a stealing and a stalling instance share stimulus
// and are each checked every cycle against a request-level reference model.
module tb_voice_scheduler;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         beat = 1'b0;
  logic         play_enable = 1'b0;
  logic         req_valid = 1'b0;
  logic [5:0]   req_note = '0;
  logic [5:0]   req_duration = '0;
  logic [1:0]   req_stereo = '0;
  logic [N-1:0] voice_done = '0;

  logic         ready_s, done_s, steal_s, ready_n, done_n, steal_n;
  logic [N-1:0] load_s, busy_s, load_n, busy_n;
  logic [6*N-1:0] note_s, dur_s, note_n, dur_n;
  logic [2*N-1:0] st_s, st_n;

  voice_scheduler #(.NUM_VOICES(N), .AGE_W(8), .STEAL_EN(1'b1)) dut_s (
    .clk(clk), .reset(reset), .beat(beat), .play_enable(play_enable),
    .req_valid(req_valid), .req_ready(ready_s), .req_note(req_note),
    .req_duration(req_duration), .req_stereo(req_stereo), .voice_done(voice_done),
    .voice_load(load_s), .voice_note(note_s), .voice_duration(dur_s),
    .voice_stereo(st_s), .voices_busy(busy_s), .req_done(done_s), .steal_pulse(steal_s)
  );

  voice_scheduler #(.NUM_VOICES(N), .AGE_W(8), .STEAL_EN(1'b0)) dut_n (
    .clk(clk), .reset(reset), .beat(beat), .play_enable(play_enable),
    .req_valid(req_valid), .req_ready(ready_n), .req_note(req_note),
    .req_duration(req_duration), .req_stereo(req_stereo), .voice_done(voice_done),
    .voice_load(load_n), .voice_note(note_n), .voice_duration(dur_n),
    .voice_stereo(st_n), .voices_busy(busy_n), .req_done(done_n), .steal_pulse(steal_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, index 0 = stealing instance, 1 = stalling instance.
  // A captured request retires two cycles after its handshake unless it has
  // to wait for a free voice; fields become visible with the load pulse.
  bit       m_busy[2][N];
  int       m_age[2][N];
  bit [5:0] m_note[2][N];
  bit [5:0] m_dur[2][N];
  bit [1:0] m_st[2][N];
  bit       m_pend[2];
  int       m_stage[2];
  bit       m_rest[2];
  bit [5:0] m_rn[2];
  bit [5:0] m_rd[2];
  bit [1:0] m_rs[2];
  int       m_sel[2];
  bit       m_steal[2];

  logic [N-1:0]   e_load, e_busy, nbusy;
  logic [6*N-1:0] e_note, e_dur;
  logic [2*N-1:0] e_st;
  logic           e_done, e_steal, e_ready, hs;
  int             p;
  bit             pst;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_pend[k] = 0; m_stage[k] = 0; m_rest[k] = 0; m_sel[k] = 0; m_steal[k] = 0;
        for (int i = 0; i < N; i++) begin
          m_busy[k][i] = 0; m_age[k][i] = 0; m_note[k][i] = 0; m_dur[k][i] = 0; m_st[k][i] = 0;
        end
      end
      e_load = '0;
      if (m_pend[k] && m_stage[k] == 2 && !m_rest[k]) e_load[m_sel[k]] = 1'b1;
      e_done  = m_pend[k] && m_stage[k] == 2;
      e_steal = (e_load != 0) && m_steal[k];
      e_ready = reset && play_enable && (!m_pend[k] || (m_stage[k] == 2 && m_rest[k]));
      for (int i = 0; i < N; i++) begin
        e_busy[i]       = m_busy[k][i];
        e_note[6*i +: 6] = m_note[k][i];
        e_dur[6*i +: 6]  = m_dur[k][i];
        e_st[2*i +: 2]   = m_st[k][i];
      end
      chk($sformatf("d%0d_load", k),  k ? load_n  : load_s,  e_load);
      chk($sformatf("d%0d_done", k),  k ? done_n  : done_s,  e_done);
      chk($sformatf("d%0d_steal", k), k ? steal_n : steal_s, e_steal);
      chk($sformatf("d%0d_ready", k), k ? ready_n : ready_s, e_ready);
      chk($sformatf("d%0d_busy", k),  k ? busy_n  : busy_s,  e_busy);
      chk($sformatf("d%0d_note", k),  k ? note_n  : note_s,  e_note);
      chk($sformatf("d%0d_dur", k),   k ? dur_n   : dur_s,   e_dur);
      chk($sformatf("d%0d_st", k),    k ? st_n    : st_s,    e_st);
      for (int i = 0; i < N; i++)
        chk($sformatf("d%0d_age%0d", k, i), k ? dut_n.age_q[i] : dut_s.age_q[i], m_age[k][i]);

      if (reset) begin
        hs = req_valid && e_ready;
        if (m_pend[k]) begin
          if (m_stage[k] == 2) m_pend[k] = 0;
          else if (m_rest[k]) m_stage[k] = 2;
          else begin
            p = -1; pst = 0;
            for (int i = 0; i < N; i++) if (p < 0 && !m_busy[k][i]) p = i;
            if (p < 0 && k == 0) begin
              p = 0; pst = 1;
              for (int i = 1; i < N; i++) if (m_age[k][i] > m_age[k][p]) p = i;
            end
            if (p >= 0) begin
              m_sel[k] = p; m_steal[k] = pst; m_stage[k] = 2;
              m_note[k][p] = m_rn[k]; m_dur[k][p] = m_rd[k]; m_st[k][p] = m_rs[k];
            end
          end
        end
        if (hs) begin
          m_pend[k] = 1; m_stage[k] = 1;
          m_rn[k] = req_note; m_rd[k] = req_duration; m_rs[k] = req_stereo;
          m_rest[k] = (req_note == 6'd0);
        end
        for (int i = 0; i < N; i++) begin
          nbusy[i] = e_load[i] || (m_busy[k][i] && !voice_done[i]);
          if (e_load[i] || !nbusy[i]) m_age[k][i] = 0;
          else if (m_busy[k][i] && beat && play_enable && m_age[k][i] < 255) m_age[k][i]++;
        end
        for (int i = 0; i < N; i++) m_busy[k][i] = nbusy[i];
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic pulse_beat();
    beat = 1'b1; sync(); beat = 1'b0; sync();
  endtask

  task automatic send(input int k, input logic [5:0] n, input logic [5:0] d,
                      input logic [1:0] s, output int t);
    req_note = n; req_duration = d; req_stereo = s; req_valid = 1'b1; t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      @(negedge clk);
      if ((k == 0) ? ready_s : ready_n) t = cyc;
      sync();
    end
    req_valid = 1'b0;
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no req_ready expected handshake within 40 cycles");
    end
  endtask

  int t;

  initial begin
    reset = 1'b0; play_enable = 1'b1;
    repeat (3) sync();
    @(negedge clk);
    chk("rst_ready_s", ready_s, 0); chk("rst_ready_n", ready_n, 0);
    chk("rst_busy", busy_s, 0);     chk("rst_load", load_s, 0);
    sync(); reset = 1'b1; repeat (2) sync();

    // fill three voices
    send(0, 6'd10, 6'd4, 2'd1, t);
    @(negedge clk); chk("fill0_early", load_s, 3'b000);
    @(negedge clk); chk("fill0_load", load_s, 3'b001); chk("fill0_done", done_s, 1);
    sync();
    send(0, 6'd20, 6'd8, 2'd2, t);
    @(negedge clk); @(negedge clk); chk("fill1_load", load_s, 3'b010);
    sync();
    send(0, 6'd30, 6'd12, 2'd3, t);
    @(negedge clk); @(negedge clk); chk("fill2_load", load_s, 3'b100);
    sync();
    @(negedge clk);
    chk("fill_busy", busy_s, 3'b111);
    chk("fill_note2", note_s[17:12], 6'd30); chk("fill_dur2", dur_s[17:12], 6'd12);
    sync();

    // staggered ages 5,9,9
    repeat (4) pulse_beat();
    voice_done = 3'b001; sync(); voice_done = '0; sync();
    send(0, 6'd50, 6'd3, 2'd0, t);
    @(negedge clk); @(negedge clk); chk("reload0", load_s, 3'b001);
    sync();
    repeat (5) pulse_beat();
    @(negedge clk);
    chk("age0", dut_s.age_q[0], 5); chk("age1", dut_s.age_q[1], 9); chk("age2", dut_s.age_q[2], 9);
    sync();

    // steal (dut_s) and stall (dut_n) on the same request
    send(0, 6'd40, 6'd7, 2'd1, t);
    @(negedge clk);
    @(negedge clk);
    chk("steal_pulse", steal_s, 1); chk("steal_load", load_s, 3'b010);
    chk("steal_note1", note_s[11:6], 6'd40);
    sync();
    @(negedge clk); chk("steal_age1", dut_s.age_q[1], 0);
    repeat (3) begin
      sync(); @(negedge clk);
      chk("stall_ready", ready_n, 0); chk("stall_done", done_n, 0);
    end
    sync();
    voice_done = 3'b100; sync(); voice_done = '0;
    @(negedge clk); chk("stall_busy2", busy_n[2], 0); chk("stall_noload", load_n, 3'b000);
    @(negedge clk); chk("stall_load", load_n, 3'b100); chk("stall_note2", note_n[17:12], 6'd40);
    chk("stall_rdone", done_n, 1);
    sync(); sync();

    // rest request
    send(0, 6'd0, 6'd6, 2'd0, t);
    @(negedge clk); chk("rest_early", done_s, 0);
    @(negedge clk);
    chk("rest_done", done_s, 1); chk("rest_load", load_s, 3'b000); chk("rest_busy", busy_s, 3'b011);
    sync();

    // done and load to voice 0 in the same cycle
    voice_done = 3'b001; sync(); voice_done = '0;
    send(0, 6'd33, 6'd5, 2'd2, t);
    sync(); voice_done = 3'b001; sync(); voice_done = '0;
    @(negedge clk); chk("samecyc_busy_s", busy_s, 3'b011); chk("samecyc_busy_n", busy_n, 3'b111);
    sync();

    // pause: no accept, ages frozen
    repeat (2) pulse_beat();
    @(negedge clk);
    chk("pre_age0", dut_s.age_q[0], 2); chk("pre_age1", dut_s.age_q[1], 2);
    sync();
    play_enable = 1'b0; req_note = 6'd9; req_valid = 1'b1;
    @(negedge clk); chk("pause_ready", ready_s, 0);
    sync();
    repeat (4) pulse_beat();
    @(negedge clk);
    chk("pause_age0", dut_s.age_q[0], 2); chk("pause_age1", dut_s.age_q[1], 2);
    chk("pause_age2", dut_s.age_q[2], 0); chk("pause_done", done_s, 0);
    sync();
    req_valid = 1'b0; play_enable = 1'b1; sync();

    // reset while the load is pending
    send(0, 6'd44, 6'd1, 2'd0, t);
    reset = 1'b0;
    sync();
    @(negedge clk);
    chk("rstload_load", load_s, 3'b000); chk("rstload_busy", busy_s, 3'b000);
    chk("rstload_ready", ready_s, 0);
    sync(); reset = 1'b1; sync();
    send(0, 6'd45, 6'd2, 2'd1, t);
    @(negedge clk); @(negedge clk); chk("post_rst_load", load_s, 3'b001);
    repeat (3) sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Allocates incoming note requests from the song reader onto a pool of NUM_VOICES note_players. It tracks which players are busy from their done pulses and issues one-cycle load pulses with the note, duration and stereo fields. When every player is busy it either steals the oldest voice or stalls the requester. It sits between the song reader and the note_player array and replaces fixed-slot note assignment.

Parameters:
NUM_VOICES, 3, number of note_players managed (2..8)
AGE_W, 8, width of the per-voice age counter (saturating)
STEAL_EN, 1, 1 = steal the oldest voice when all are busy; 0 = stall until a voice frees

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; all state cleared while low
beat  in  1  one-cycle pulse per 48th note from the beat generator
play_enable  in  1  high = accept and allocate; low = hold (pause)
req_valid  in  1  request present on req_* fields
req_ready  out  1  scheduler can accept this cycle
req_note  in  6  pitch; 0 = rest
req_duration  in  6  duration in beats
req_stereo  in  2  stereo select
voice_done  in  NUM_VOICES  one-cycle done pulses, bit i from note_player i
voice_load  out  NUM_VOICES  one-cycle load pulse, bit i to note_player i
voice_note  out  6*NUM_VOICES  per-voice note, voice i at [6i+5:6i]
voice_duration  out  6*NUM_VOICES  per-voice duration, same packing
voice_stereo  out  2*NUM_VOICES  per-voice stereo, voice i at [2i+1:2i]
voices_busy  out  NUM_VOICES  registered busy map
req_done  out  1  one-cycle pulse when a request is retired (loaded or dropped rest)
steal_pulse  out  1  one-cycle pulse when an allocation evicts a busy voice

Behaviour:
- Reset (reset low, async): state=IDLE. All outputs are 0: voice_* fields, voices_busy, voice_load, req_done, steal_pulse. All ages are 0. req_ready=0 while reset is asserted.
- FSM states and transitions:
  - IDLE: req_ready = play_enable. A handshake (req_valid & req_ready) captures req_* into the request register. If req_note==0, go to DONE. Otherwise go to ALLOC.
  - ALLOC: select the lowest-index free voice (busy=0).
  - If no voice is free and STEAL_EN=1, select the voice with the largest age. Ties go to the lowest index. Set steal_pulse.
  - If no voice is free and STEAL_EN=0, stay in ALLOC with no selection.
  - With a selection made, go to LOAD.
  - LOAD: write the request fields into the selected voice's output registers. Pulse voice_load[sel] and req_done for this one cycle. Set busy[sel]=1 and age[sel]=0. Go to IDLE.
  - DONE (rest): pulse req_done for one cycle and do not touch any voice. Go to IDLE.
- Latency: a handshake in cycle T gives voice_load in T+2 and req_done in T+2. voice_note/duration/stereo for that voice are stable from T+2 onward; note_players sample them on the load pulse. Throughput is one request per 3 cycles.
- Busy tracking: voice_done[i] clears busy[i] at the next edge. If voice_done[i] and a LOAD to voice i occur in the same cycle, the load wins and busy[i] stays 1.
- Age: on each beat with play_enable=1, every busy voice's age increments and saturates at 2^AGE_W-1. Free voices hold age 0.
- play_enable low:
  - req_ready=0 and ages freeze.
  - ALLOC and LOAD still complete a request already captured; pause never splits a handshake.
  - Done pulses are still processed.
- Multiple done bits in one cycle clear all corresponding busy bits.
- Voice output fields hold their last loaded value when idle. They are not cleared on done.
- voices_busy is a direct register output.
- No combinational path from req_valid to voice_load.

Decomposition:
- Shared package (voice_pkg): FSM state encodings IDLE/ALLOC/LOAD/DONE; NOTE_W=6, DUR_W=6, STEREO_W=2; constant REST_NOTE=6'd0.
- One sub-module is natural: voice_picker. It is purely combinational. Inputs are the busy map and the age vector. Outputs are sel index, sel_valid and sel_is_steal, implementing the lowest-free/oldest-busy priority.
- Counters and FSM stay in voice_scheduler, using the codebase dffr-style registers adapted for the active-low async reset.

Test Plan:
- Reset mid-LOAD: pull reset low in the cycle voice_load would fire. Required: voice_load stays 0, voices_busy=000, req_ready=0, and the next request after release goes to voice 0.
- Fill three voices with notes 10, 20, 30 (durations 4, 8, 12), no done pulses. Required: voice_load=001, 010, 100 in order; each at handshake+2; voices_busy=111; voice_note[17:12]=30.
- STEAL_EN=1, all busy. Ages are 5, 9, 9 from beats applied after staggered loads. Send note 40. Required: steal_pulse, voice_load=010, voice_note[11:6]=40, age[1]=0.
- STEAL_EN=0, all busy, send note 40. Required: req_done stays 0 and req_ready stays 0. Pulse voice_done=100. Required: voice_load=100 exactly 1 cycle after busy[2] clears.
- Rest request (req_note=0, duration 6). Required: req_done at T+2, voice_load=000, voices_busy unchanged.
- Same-cycle voice_done[0] with a LOAD to voice 0. Required: busy[0] remains 1. Separately: play_enable=0 gives req_ready=0 and ages frozen across 4 beats.
